// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronise and debounce raw slide-switch pins, emit edge pulses
// and, when SWITCH_DEBOUNCER_EVENT_EN is defined, a sticky change-event mask with ack.
module switch_debouncer #(
  parameter int WIDTH         = 10,
  parameter int STABLE_CYCLES = 500000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             evt_valid,
  output logic [WIDTH-1:0] evt_mask,
  input  logic             evt_ack,
  output logic             init_done
);
  localparam int CNT_W = $clog2(STABLE_CYCLES + SYNC_STAGES);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(STABLE_CYCLES + SYNC_STAGES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                              state_q, state_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]   sync_q, sync_d;
  logic [WIDTH-1:0][CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]                    init_cnt_q, init_cnt_d;
  logic [WIDTH-1:0]                    sw_clean_q, sw_clean_d;
  logic [WIDTH-1:0]                    sw_rise_q, sw_rise_d;
  logic [WIDTH-1:0]                    sw_fall_q, sw_fall_d;
  logic                                init_done_q, init_done_d;
  logic [WIDTH-1:0]                    sync;

  assign sync      = sync_q[SYNC_STAGES-1];
  assign sw_clean  = sw_clean_q;
  assign sw_rise   = sw_rise_q;
  assign sw_fall   = sw_fall_q;
  assign init_done = init_done_q;

  // Shift raw pins through the synchroniser chain; stage 0 is the only sampler of sw_raw.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sw_raw};
  end

  // INIT adopts the synchronised state silently; RUN debounces each channel on its own counter.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    sw_clean_d  = sw_clean_q;
    sw_rise_d   = '0;
    sw_fall_d   = '0;
    cnt_d       = '0;
    if (state_q == INIT) begin
      sw_clean_d = sync;
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == INIT_LAST) begin
        state_d     = RUN;
        init_done_d = 1'b1;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == sw_clean_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          sw_clean_d[i] = sync[i];
          sw_rise_d[i]  = sync[i];
          sw_fall_d[i]  = ~sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // State, counters and debounced outputs, all cleared asynchronously.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= INIT;
      sync_q      <= '0;
      cnt_q       <= '0;
      init_cnt_q  <= '0;
      sw_clean_q  <= '0;
      sw_rise_q   <= '0;
      sw_fall_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      init_cnt_q  <= init_cnt_d;
      sw_clean_q  <= sw_clean_d;
      sw_rise_q   <= sw_rise_d;
      sw_fall_q   <= sw_fall_d;
      init_done_q <= init_done_d;
    end
  end

`ifdef SWITCH_DEBOUNCER_EVENT_EN
  logic [WIDTH-1:0] evt_mask_q, evt_mask_d;
  logic             evt_valid_q, evt_valid_d;

  assign evt_mask  = evt_mask_q;
  assign evt_valid = evt_valid_q;

  // Accumulate edges; an edge arriving with ack survives because the pulses are OR-ed after the clear.
  always_comb begin
    evt_mask_d  = (state_q == INIT) ? '0 : ((evt_ack ? '0 : evt_mask_q) | sw_rise_q | sw_fall_q);
    evt_valid_d = |evt_mask_d;
  end

  // Event mask and its valid flag are registered together so they always agree.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      evt_mask_q  <= '0;
      evt_valid_q <= 1'b0;
    end else begin
      evt_mask_q  <= evt_mask_d;
      evt_valid_q <= evt_valid_d;
    end
  end
`else
  logic unused_evt_ack;

  assign unused_evt_ack = evt_ack;
  assign evt_mask       = '0;
  assign evt_valid      = 1'b0;
`endif
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed table plus corner-case sequences for switch_debouncer.
module tb_switch_debouncer;
`ifdef SWITCH_DEBOUNCER_EVENT_EN
  localparam logic [9:0] EM = 10'h3FF;
`else
  localparam logic [9:0] EM = 10'h000;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] sw_raw = 10'h155;
  logic       evt_ack = 1'b0;
  logic [9:0] sw_clean, sw_rise, sw_fall, evt_mask;
  logic       evt_valid, init_done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  switch_debouncer #(.WIDTH(10), .STABLE_CYCLES(8), .SYNC_STAGES(2)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .sw_raw(sw_raw), .sw_clean(sw_clean),
    .sw_rise(sw_rise), .sw_fall(sw_fall), .evt_valid(evt_valid), .evt_mask(evt_mask),
    .evt_ack(evt_ack), .init_done(init_done)
  );

  typedef struct {
    bit         rst;
    logic [9:0] raw;
    bit         ack;
    int         cyc;
    logic [9:0] clean;
    logic [9:0] rise;
    logic [9:0] fall;
    logic [9:0] mask;
    bit         init;
  } vec_t;

  vec_t tbl[16];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic ack_pulse();
    evt_ack = 1'b1;
    step(1);
    evt_ack = 1'b0;
  endtask

  initial begin
    int flip_at, rise_cnt, bounce_bad, pulses, k;
    tbl[0]  = '{1'b0, 10'h155, 1'b0, 2, 10'h000, 10'h000, 10'h000, 10'h000, 1'b0};
    tbl[1]  = '{1'b1, 10'h155, 1'b0, 3, 10'h155, 10'h000, 10'h000, 10'h000, 1'b0};
    tbl[2]  = '{1'b1, 10'h155, 1'b0, 6, 10'h155, 10'h000, 10'h000, 10'h000, 1'b0};
    tbl[3]  = '{1'b1, 10'h155, 1'b0, 1, 10'h155, 10'h000, 10'h000, 10'h000, 1'b1};
    tbl[4]  = '{1'b1, 10'h15D, 1'b0, 9, 10'h155, 10'h000, 10'h000, 10'h000, 1'b1};
    tbl[5]  = '{1'b1, 10'h15D, 1'b0, 1, 10'h15D, 10'h008, 10'h000, 10'h000, 1'b1};
    tbl[6]  = '{1'b1, 10'h15D, 1'b0, 1, 10'h15D, 10'h000, 10'h000, 10'h008, 1'b1};
    tbl[7]  = '{1'b1, 10'h15D, 1'b0, 3, 10'h15D, 10'h000, 10'h000, 10'h008, 1'b1};
    tbl[8]  = '{1'b1, 10'h15D, 1'b1, 1, 10'h15D, 10'h000, 10'h000, 10'h000, 1'b1};
    tbl[9]  = '{1'b1, 10'h15D, 1'b1, 1, 10'h15D, 10'h000, 10'h000, 10'h000, 1'b1};
    tbl[10] = '{1'b1, 10'h15D, 1'b0, 1, 10'h15D, 10'h000, 10'h000, 10'h000, 1'b1};
    tbl[11] = '{1'b1, 10'h159, 1'b0, 9, 10'h15D, 10'h000, 10'h000, 10'h000, 1'b1};
    tbl[12] = '{1'b1, 10'h159, 1'b0, 1, 10'h159, 10'h000, 10'h004, 10'h000, 1'b1};
    tbl[13] = '{1'b1, 10'h159, 1'b0, 1, 10'h159, 10'h000, 10'h000, 10'h004, 1'b1};
    tbl[14] = '{1'b1, 10'h159, 1'b1, 1, 10'h159, 10'h000, 10'h000, 10'h000, 1'b1};
    tbl[15] = '{1'b1, 10'h159, 1'b0, 1, 10'h159, 10'h000, 10'h000, 10'h000, 1'b1};

    #2;
    for (int i = 0; i < 16; i++) begin
      rst_n   = tbl[i].rst;
      sw_raw  = tbl[i].raw;
      evt_ack = tbl[i].ack;
      step(tbl[i].cyc);
      chk($sformatf("r%0d_clean", i), 32'(sw_clean), 32'(tbl[i].clean));
      chk($sformatf("r%0d_rise", i), 32'(sw_rise), 32'(tbl[i].rise));
      chk($sformatf("r%0d_fall", i), 32'(sw_fall), 32'(tbl[i].fall));
      chk($sformatf("r%0d_mask", i), 32'(evt_mask), 32'(tbl[i].mask & EM));
      chk($sformatf("r%0d_valid", i), 32'(evt_valid), 32'((tbl[i].mask & EM) != 0));
      chk($sformatf("r%0d_init", i), 32'(init_done), 32'(tbl[i].init));
    end

    // Bounce on channel 0: bring it low first, then chatter, then settle high.
    sw_raw = 10'h158;
    step(12);
    chk("bounce_pre_clean", 32'(sw_clean), 32'h158);
    ack_pulse();
    bounce_bad = 0;
    for (int c = 0; c < 40; c++) begin
      sw_raw[0] = ((c / 3) % 2 == 0);
      step(1);
      if (sw_clean !== 10'h158 || sw_rise !== 10'h000) bounce_bad++;
    end
    chk("bounce_hold", 32'(bounce_bad), 32'd0);
    sw_raw[0] = 1'b1;
    flip_at = 0;
    rise_cnt = 0;
    for (int j = 1; j <= 20; j++) begin
      step(1);
      if (sw_rise[0]) rise_cnt++;
      if (sw_clean[0] && flip_at == 0) flip_at = j;
    end
    chk_rng("bounce_latency", flip_at, 9, 11);
    chk("bounce_rise_count", 32'(rise_cnt), 32'd1);
    chk("bounce_clean", 32'(sw_clean), 32'h159);
    chk("bounce_mask", 32'(evt_mask), 32'(10'h001 & EM));

    // Ack race: ack lands in the same cycle as the fall pulse on channel 5.
    ack_pulse();
    sw_raw = 10'h179;
    step(12);
    chk("race_setup_clean", 32'(sw_clean), 32'h179);
    ack_pulse();
    sw_raw = 10'h171;
    step(12);
    chk("race_mask_pre", 32'(evt_mask), 32'(10'h008 & EM));
    sw_raw = 10'h151;
    k = 0;
    while (sw_fall == 10'h000 && k < 14) begin
      step(1);
      k++;
    end
    chk("race_fall", 32'(sw_fall), 32'h020);
    evt_ack = 1'b1;
    step(1);
    chk("race_mask_kept", 32'(evt_mask), 32'(10'h020 & EM));
    chk("race_valid_kept", 32'(evt_valid), 32'((10'h020 & EM) != 0));
    step(1);
    chk("race_mask_cleared", 32'(evt_mask), 32'h000);
    chk("race_valid_cleared", 32'(evt_valid), 32'd0);
    evt_ack = 1'b0;

    // All channels flip together.
    sw_raw = 10'h000;
    step(12);
    ack_pulse();
    chk("multi_pre_clean", 32'(sw_clean), 32'h000);
    sw_raw = 10'h3FF;
    k = 0;
    while (sw_rise == 10'h000 && k < 14) begin
      step(1);
      k++;
    end
    chk("multi_rise", 32'(sw_rise), 32'h3FF);
    chk("multi_clean", 32'(sw_clean), 32'h3FF);
    step(1);
    chk("multi_mask", 32'(evt_mask), 32'(10'h3FF & EM));
    chk("multi_valid", 32'(evt_valid), 32'((10'h3FF & EM) != 0));
    chk("multi_rise_gone", 32'(sw_rise), 32'h000);

    // Reset in the middle of a count on channel 9.
    sw_raw = 10'h1FF;
    step(7);
    rst_n = 1'b0;
    #1;
    chk("rst_clean", 32'(sw_clean), 32'h000);
    chk("rst_rise", 32'(sw_rise), 32'h000);
    chk("rst_fall", 32'(sw_fall), 32'h000);
    chk("rst_mask", 32'(evt_mask), 32'h000);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_init", 32'(init_done), 32'd0);
    step(2);
    rst_n = 1'b1;
    pulses = 0;
    for (int j = 0; j < 10; j++) begin
      step(1);
      if (sw_rise != 10'h000 || sw_fall != 10'h000 || evt_mask != 10'h000) pulses++;
    end
    chk("rst_reinit_done", 32'(init_done), 32'd1);
    chk("rst_reinit_clean", 32'(sw_clean), 32'h1FF);
    chk("rst_reinit_quiet", 32'(pulses), 32'd0);
    step(3);
    chk("rst_run_quiet", 32'(evt_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
